// File: rtl/data_memory_responder_pkg.sv
// Shared core package for the data memory responder.
// Holds the load/store op encoding, FSM state type and small decode helpers.
package data_memory_responder_pkg;

    // Access size and signedness; the initiator performs sign extension.
    typedef enum logic [2:0] {
        MemB  = 3'b000,
        MemH  = 3'b001,
        MemW  = 3'b010,
        MemBU = 3'b100,
        MemHU = 3'b101
    } mem_op_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } dm_state_e;

    // Access size codes (op[1:0] for legal ops).
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    function automatic logic op_legal(input logic [2:0] op);
        logic ok;
        case (op)
            MemB, MemH, MemW, MemBU, MemHU: ok = 1'b1;
            default:                        ok = 1'b0;
        endcase
        return ok;
    endfunction

    // True when the byte offset is not naturally aligned for the size.
    function automatic logic misaligned(
        input logic [1:0] size,
        input logic [1:0] lane
    );
        logic bad;
        case (size)
            SZ_HALF: bad = lane[0];
            SZ_WORD: bad = |lane;
            default: bad = 1'b0;
        endcase
        return bad;
    endfunction

    // Byte enables for a store of the given size at the given lane.
    function automatic logic [3:0] lane_mask(
        input logic [1:0] size,
        input logic [1:0] lane
    );
        logic [3:0] be;
        case (size)
            SZ_BYTE: be = 4'b0001 << lane;
            SZ_HALF: be = lane[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/data_memory_ram.sv
// Single-port word RAM with per-byte write enables and a registered read.
// Ports: clk, we, be[3:0], addr (word index), wdata, q (read data, 1 cycle).
module data_memory_ram #(
    parameter int XLEN        = 32,
    parameter int DEPTH_WORDS = 1024,
    localparam int AW         = $clog2(DEPTH_WORDS)
) (
    input  logic            clk,
    input  logic            we,
    input  logic [3:0]      be,
    input  logic [AW-1:0]   addr,
    input  logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] q
);

    logic [XLEN-1:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem[addr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    // Read-before-write: q shows the word as it was before this edge.
    always_ff @(posedge clk) begin
        q <= mem[addr];
    end

endmodule

// File: rtl/data_memory_responder.sv
// Data memory responder: accepts one load/store, answers two cycles later.
// Ports: i_clk/i_rst, request (avalid/aready/addr/wvalid/op/wdata),
// response (rvalid/rready/rdata/rerr).
module data_memory_responder
    import data_memory_responder_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int DEPTH_WORDS = 1024
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_dm_avalid,
    output logic            o_dm_aready,
    input  logic [XLEN-1:0] i_dm_addr,
    input  logic            i_dm_wvalid,
    input  logic [2:0]      i_dm_op_data,
    input  logic [XLEN-1:0] i_dm_wdata,
    output logic            o_dm_rvalid,
    input  logic            i_dm_rready,
    output logic [XLEN-1:0] o_dm_rdata,
    output logic            o_dm_rerr
);

    localparam int AW = $clog2(DEPTH_WORDS);

    dm_state_e       state;

    logic [AW-1:0]   req_idx;
    logic [1:0]      req_lane;
    logic [1:0]      req_size;
    logic            req_store;
    logic            req_err;
    logic [XLEN-1:0] req_wdata;

    logic            in_err;
    logic            accept;

    logic [AW-1:0]   ram_addr;
    logic            ram_we;
    logic [3:0]      ram_be;
    logic [XLEN-1:0] ram_wdata;
    logic [XLEN-1:0] ram_q;

    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] load_data;

    assign accept = i_dm_avalid && o_dm_aready;

    // Fault check on the incoming request, registered at acceptance.
    always_comb begin
        in_err = 1'b0;
        if (!op_legal(i_dm_op_data)) begin
            in_err = 1'b1;
        end
        if (misaligned(i_dm_op_data[1:0], i_dm_addr[1:0])) begin
            in_err = 1'b1;
        end
        if (|i_dm_addr[XLEN-1:AW+2]) begin
            in_err = 1'b1;
        end
    end

    // The RAM is read at the acceptance edge so its registered output is
    // ready during ACCESS; the write of a store lands at the ACCESS edge.
    always_comb begin
        ram_addr  = (state == IDLE) ? i_dm_addr[AW+1:2] : req_idx;
        ram_we    = (state == ACCESS) && req_store && !req_err && !i_rst;
        ram_be    = lane_mask(req_size, req_lane);
        ram_wdata = req_wdata << {req_lane, 3'b000};
    end

    data_memory_ram #(
        .XLEN        (XLEN),
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_ram (
        .clk   (i_clk),
        .we    (ram_we),
        .be    (ram_be),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .q     (ram_q)
    );

    // Right-justify the addressed lane and clear bits above the size.
    always_comb begin
        shifted   = ram_q >> {req_lane, 3'b000};
        load_data = shifted;
        case (req_size)
            SZ_BYTE: load_data = {{(XLEN-8){1'b0}}, shifted[7:0]};
            SZ_HALF: load_data = {{(XLEN-16){1'b0}}, shifted[15:0]};
            default: load_data = shifted;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= IDLE;
            o_dm_aready <= 1'b1;
            o_dm_rvalid <= 1'b0;
            o_dm_rerr   <= 1'b0;
            o_dm_rdata  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        req_idx     <= i_dm_addr[AW+1:2];
                        req_lane    <= i_dm_addr[1:0];
                        req_size    <= i_dm_op_data[1:0];
                        req_store   <= i_dm_wvalid;
                        req_err     <= in_err;
                        req_wdata   <= i_dm_wdata;
                        o_dm_aready <= 1'b0;
                        state       <= ACCESS;
                    end
                end
                ACCESS: begin
                    o_dm_rvalid <= 1'b1;
                    o_dm_rerr   <= req_err;
                    // Stores and faulted requests answer with zero data.
                    if (req_err || req_store) begin
                        o_dm_rdata <= '0;
                    end else begin
                        o_dm_rdata <= load_data;
                    end
                    state <= RESP;
                end
                RESP: begin
                    if (i_dm_rready) begin
                        o_dm_rvalid <= 1'b0;
                        o_dm_rerr   <= 1'b0;
                        o_dm_rdata  <= '0;
                        o_dm_aready <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    o_dm_rvalid <= 1'b0;
                    o_dm_aready <= 1'b1;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_memory_responder.sv
// Randomized bench for data_memory_responder against a byte-array model.
// Directed cases cover the listed scenarios; the rest is random traffic.
module tb_data_memory_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        avalid;
    logic        aready;
    logic [31:0] addr;
    logic        wvalid;
    logic [2:0]  op;
    logic [31:0] wdata;
    logic        rvalid;
    logic        rready;
    logic [31:0] rdata;
    logic        rerr;

    int nchecks = 0;
    int nerrors = 0;

    // Byte-addressed reference memory, little-endian.
    logic [7:0] mem_b [4096];

    always #5 clk = ~clk;

    data_memory_responder #(
        .XLEN        (32),
        .DEPTH_WORDS (1024)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_dm_avalid  (avalid),
        .o_dm_aready  (aready),
        .i_dm_addr    (addr),
        .i_dm_wvalid  (wvalid),
        .i_dm_op_data (op),
        .i_dm_wdata   (wdata),
        .o_dm_rvalid  (rvalid),
        .i_dm_rready  (rready),
        .o_dm_rdata   (rdata),
        .o_dm_rerr    (rerr)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        nchecks++;
        if (got !== exp) begin
            nerrors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference behaviour: size from op, natural alignment, range check,
    // byte-wise store, zero-extended load.
    task automatic model(input bit st, input logic [2:0] o,
                         input logic [31:0] a, input logic [31:0] wd,
                         output logic e, output logic [31:0] rd);
        int size;
        case (o)
            3'd0, 3'd4: size = 1;
            3'd1, 3'd5: size = 2;
            3'd2:       size = 4;
            default:    size = 0;
        endcase
        e  = (size == 0) || (a >= 32'd4096) || ((a % size) != 0);
        rd = 32'h0;
        if (!e) begin
            for (int i = 0; i < size; i++) begin
                if (st) mem_b[a + i] = wd[8*i +: 8];
                else    rd[8*i +: 8] = mem_b[a + i];
            end
        end
    endtask

    task automatic txn(input bit st, input logic [2:0] o,
                       input logic [31:0] a, input logic [31:0] wd,
                       input int hold,
                       output logic [31:0] rd, output logic re);
        logic [31:0] er;
        logic        ee;
        int          n;
        model(st, o, a, wd, ee, er);
        @(negedge clk);
        chk("aready_idle", aready, 1'b1);
        avalid = 1'b1;
        wvalid = st;
        op     = o;
        addr   = a;
        wdata  = wd;
        @(posedge clk);
        #1;
        avalid = 1'b0;
        wvalid = 1'b0;
        addr   = $urandom;
        wdata  = $urandom;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rvalid && n < 8);
        chk("latency", n, 2);
        rd = rdata;
        re = rerr;
        if (!rvalid) return;
        chk("rdata", rdata, er);
        chk("rerr", rerr, ee);
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            chk("hold_rvalid", rvalid, 1'b1);
            chk("hold_rdata", rdata, er);
            chk("hold_rerr", rerr, ee);
            chk("hold_aready", aready, 1'b0);
        end
        rready = 1'b1;
        @(posedge clk);
        #1;
        rready = 1'b0;
        @(negedge clk);
        chk("rvalid_clr", rvalid, 1'b0);
        chk("aready_back", aready, 1'b1);
    endtask

    logic [31:0] rd;
    logic        re;
    logic [2:0]  ops [8] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd2, 3'd3, 3'd7};

    initial begin
        rst    = 1'b1;
        avalid = 1'b0;
        wvalid = 1'b0;
        op     = 3'd0;
        addr   = '0;
        wdata  = '0;
        rready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_aready", aready, 1'b1);
        chk("rst_rvalid", rvalid, 1'b0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_rerr", rerr, 1'b0);

        // Fill the working window so every model byte is defined.
        for (int w = 0; w < 16; w++) begin
            txn(1'b1, 3'd2, 32'(4 * w), $urandom, 0, rd, re);
        end

        txn(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 0, rd, re);
        chk("sw_rdata0", rd, 32'h0);
        txn(1'b0, 3'd2, 32'h10, 32'h0, 0, rd, re);
        chk("lw_deadbeef", rd, 32'hDEADBEEF);
        chk("lw_rerr", re, 1'b0);
        txn(1'b1, 3'd0, 32'h12, 32'h55, 0, rd, re);
        txn(1'b0, 3'd2, 32'h10, 32'h0, 0, rd, re);
        chk("lw_merged", rd, 32'hDE55BEEF);
        txn(1'b0, 3'd4, 32'h13, 32'h0, 0, rd, re);
        chk("lbu_13", rd, 32'h000000DE);
        txn(1'b1, 3'd1, 32'h11, 32'hFFFF, 0, rd, re);
        chk("sh_mis_err", re, 1'b1);
        chk("sh_mis_rdata", rd, 32'h0);
        txn(1'b0, 3'd2, 32'h10, 32'h0, 0, rd, re);
        chk("lw_unchanged", rd, 32'hDE55BEEF);
        txn(1'b0, 3'd2, 32'h1000, 32'h0, 0, rd, re);
        chk("range_err", re, 1'b1);
        txn(1'b0, 3'd3, 32'h10, 32'h0, 0, rd, re);
        chk("badop_err", re, 1'b1);
        txn(1'b0, 3'd2, 32'h10, 32'h0, 5, rd, re);
        chk("hold_final", rd, 32'hDE55BEEF);

        // Reset during ACCESS of a store must drop it entirely.
        txn(1'b1, 3'd2, 32'h20, 32'hCAFEF00D, 0, rd, re);
        @(negedge clk);
        avalid = 1'b1;
        wvalid = 1'b1;
        op     = 3'd2;
        addr   = 32'h20;
        wdata  = 32'h12345678;
        @(posedge clk);
        #1;
        avalid = 1'b0;
        wvalid = 1'b0;
        @(negedge clk);
        chk("acc_aready", aready, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_aready", aready, 1'b1);
        chk("abort_rvalid", rvalid, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("abort_quiet", rvalid, 1'b0);
        end
        txn(1'b0, 3'd2, 32'h20, 32'h0, 0, rd, re);
        chk("abort_kept", rd, 32'hCAFEF00D);

        for (int t = 0; t < 200; t++) begin
            logic [31:0] a;
            logic [2:0]  o;
            o = ops[$urandom_range(0, 7)];
            if ($urandom_range(0, 9) == 0) a = 32'h1000 + $urandom_range(0, 255);
            else                           a = $urandom_range(0, 63);
            txn($urandom_range(0, 1) == 1, o, a, $urandom,
                $urandom_range(0, 2), rd, re);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 nchecks, nerrors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/data_memory_responder.md
DATA_MEMORY_RESPONDER -- requirements
Module: data_memory_responder

Interface
REQ-001 Parameter XLEN, default 32, data/address width in bits.
REQ-002 Parameter DEPTH_WORDS, default 1024, storage depth in XLEN-bit words (power of two).
REQ-003 i_clk  input  1  sole clock; all state updates on rising edge.
REQ-004 i_rst  input  1  synchronous, active-high reset.
REQ-005 i_dm_avalid  input  1  request valid.
REQ-006 o_dm_aready  output  1  responder can accept a request.
REQ-007 i_dm_addr  input  XLEN  byte address.
REQ-008 i_dm_wvalid  input  1  1 = store, 0 = load; qualified by the request handshake.
REQ-009 i_dm_op_data  input  3  access size/type (MemB, MemH, MemW, MemBU, MemHU).
REQ-010 i_dm_wdata  input  XLEN  store data, right-justified (byte in [7:0], half in [15:0]).
REQ-011 o_dm_rvalid  output  1  response valid.
REQ-012 i_dm_rready  input  1  initiator accepts response.
REQ-013 o_dm_rdata  output  XLEN  load data, right-justified, upper bits zero (initiator extends).
REQ-014 o_dm_rerr  output  1  request faulted (misaligned, out of range, bad op).

Function
REQ-015 The FSM SHALL have states IDLE, ACCESS and RESP.
REQ-016 o_dm_aready SHALL be 1 only in IDLE.
REQ-017 A request is accepted when i_dm_avalid && o_dm_aready; addr, wvalid, op and wdata SHALL be captured that cycle and the FSM SHALL go IDLE->ACCESS.
REQ-018 ACCESS SHALL last exactly one cycle, perform the memory read or byte-enabled write, then go to RESP.
REQ-019 o_dm_rvalid SHALL assert in RESP, two cycles after acceptance, and hold with o_dm_rdata/o_dm_rerr stable until i_dm_rready.
REQ-020 RESP && i_dm_rready SHALL return to IDLE next cycle; no new request is accepted in that same cycle.
REQ-021 Word index SHALL be addr[$clog2(DEPTH_WORDS)+1:2]; lane SHALL be addr[1:0].
REQ-022 Stores SHALL write only enabled lanes: MemB lane addr[1:0]; MemH lanes {addr[1],0} and {addr[1],1}; MemW all four; data shifted left by 8*addr[1:0].
REQ-023 MemBU/MemHU with wvalid=1 SHALL be treated as MemB/MemH stores.
REQ-024 Loads SHALL shift the word right by 8*addr[1:0] and zero bits above the access size.
REQ-025 Stores SHALL respond with o_dm_rdata = 0.
REQ-026 Error SHALL be set for: half with addr[0]=1; word with addr[1:0]!=0; addr >= 4*DEPTH_WORDS; op encoding not in REQ-009.
REQ-027 A faulted request SHALL not modify memory, SHALL return o_dm_rdata = 0 and SHALL keep the same 2-cycle latency.
REQ-028 A load following a store to the same word SHALL return the updated data.

Reset
REQ-029 On i_rst: FSM to IDLE, o_dm_rvalid=0, o_dm_rerr=0, o_dm_rdata=0, o_dm_aready=1 the following cycle.
REQ-030 Reset in ACCESS or RESP SHALL abandon the request without a response; a write in ACCESS coincident with i_rst SHALL be suppressed.
REQ-031 Storage contents SHALL NOT be cleared by reset.

Structure
REQ-032 The MemOp encoding (MemB=3'b000, MemH=3'b001, MemW=3'b010, MemBU=3'b100, MemHU=3'b101) and the FSM state typedef SHALL live in the shared core package.
REQ-033 Storage SHALL be a sub-module data_memory_ram: one read/write port, 4-bit byte enable, registered read, no reset.

Verification
REQ-034 Store MemW 0xDEADBEEF @0x10, then load MemW @0x10 -> rdata 0xDEADBEEF, rerr 0, rvalid 2 cycles after each accept.
REQ-035 Then store MemB 0x55 @0x12 and load MemW @0x10 -> 0xDE55BEEF; load MemBU @0x13 -> 0x000000DE.
REQ-036 Store MemH @0x11 -> rerr 1 with rdata 0; subsequent load MemW @0x10 unchanged.
REQ-037 Load @0x1000 with DEPTH_WORDS=1024 -> rerr 1; op 3'b011 -> rerr 1.
REQ-038 Hold i_dm_rready=0 for 5 cycles in RESP -> rvalid, rdata and rerr stable, aready 0; accept on cycle 6.
REQ-039 Assert i_rst during ACCESS of a store 0x12345678 @0x20 -> no response, IDLE next cycle, word @0x20 keeps its prior value.
